// File: rtl/sb_drain.sv
// Store-buffer drain engine: pops {adr, dat, sel} entries and retires each as one bus write.
// Define SB_DRAIN_PREFETCH_EN to add a one-entry hold register for back-to-back writes.
module sb_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ADDR_WIDTH+DATA_WIDTH+SEL_WIDTH-1:0] fifo_rd_data_i,
  input  logic                                      fifo_empty_i,
  output logic                                      fifo_rd_en_o,
  output logic                                      bus_req_o,
  output logic [ADDR_WIDTH-1:0]                     bus_adr_o,
  output logic [DATA_WIDTH-1:0]                     bus_dat_o,
  output logic [SEL_WIDTH-1:0]                      bus_sel_o,
  input  logic                                      bus_ack_i,
  input  logic                                      bus_err_i,
  output logic                                      err_o,
  output logic                                      drained_o
);

  localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH + SEL_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, BUS} state_t;

  state_t                 state_reg, state_next;
  logic [ENTRY_WIDTH-1:0] entry_reg, entry_next;
  logic                   req_reg, req_next;
  logic                   err_reg, err_next;
  logic                   rd_en;
  logic                   term;

  assign term = bus_ack_i | bus_err_i;

`ifdef SB_DRAIN_PREFETCH_EN
  // pend_reg: a pop into the hold slot was issued last cycle, so its entry is on fifo_rd_data_i now.
  logic                   hold_valid_reg, hold_valid_next;
  logic                   pend_reg, pend_next;
  logic [ENTRY_WIDTH-1:0] hold_reg, hold_next;
  logic                   avail;

  assign avail = hold_valid_reg | pend_reg;
`endif

  always_comb begin
    state_next = state_reg;
    entry_next = entry_reg;
    err_next   = 1'b0;
    rd_en      = 1'b0;
`ifdef SB_DRAIN_PREFETCH_EN
    hold_valid_next = hold_valid_reg;
    hold_next       = hold_reg;
    pend_next       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty_i) begin
          rd_en      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        entry_next = fifo_rd_data_i;
        state_next = BUS;
`ifdef SB_DRAIN_PREFETCH_EN
        if (!fifo_empty_i) begin
          rd_en     = 1'b1;
          pend_next = 1'b1;
        end
`endif
      end
      BUS: begin
        err_next = bus_err_i;
`ifdef SB_DRAIN_PREFETCH_EN
        if (term && avail) begin
          // Back-to-back: next write comes from the hold slot, request stays high.
          entry_next      = hold_valid_reg ? hold_reg : fifo_rd_data_i;
          hold_valid_next = 1'b0;
          if (!fifo_empty_i) begin
            rd_en     = 1'b1;
            pend_next = 1'b1;
          end
        end else if (term) begin
          if (!fifo_empty_i) begin
            rd_en      = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (pend_reg) begin
            hold_next       = fifo_rd_data_i;
            hold_valid_next = 1'b1;
          end else if (!hold_valid_reg && !fifo_empty_i) begin
            rd_en     = 1'b1;
            pend_next = 1'b1;
          end
        end
`else
        if (term) begin
          if (!fifo_empty_i) begin
            rd_en      = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    req_next = (state_next == BUS);
    if (rst) begin
      rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      entry_reg <= '0;
      req_reg   <= 1'b0;
      err_reg   <= 1'b0;
`ifdef SB_DRAIN_PREFETCH_EN
      hold_valid_reg <= 1'b0;
      pend_reg       <= 1'b0;
      hold_reg       <= '0;
`endif
    end else begin
      state_reg <= state_next;
      entry_reg <= entry_next;
      req_reg   <= req_next;
      err_reg   <= err_next;
`ifdef SB_DRAIN_PREFETCH_EN
      hold_valid_reg <= hold_valid_next;
      pend_reg       <= pend_next;
      hold_reg       <= hold_next;
`endif
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign bus_req_o    = req_reg;
  assign err_o        = err_reg;
  assign bus_adr_o    = entry_reg[ENTRY_WIDTH-1 -: ADDR_WIDTH];
  assign bus_dat_o    = entry_reg[SEL_WIDTH +: DATA_WIDTH];
  assign bus_sel_o    = entry_reg[SEL_WIDTH-1:0];

`ifdef SB_DRAIN_PREFETCH_EN
  assign drained_o = (state_reg == IDLE) & fifo_empty_i & ~hold_valid_reg;
`else
  assign drained_o = (state_reg == IDLE) & fifo_empty_i;
`endif

endmodule

// File: tb/tb_sb_drain.sv
// Directed bench for sb_drain: behavioural FIFO model plus per-scenario tasks with inline checks.
module tb_sb_drain;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int EW = AW + DW + SW;

  logic          clk = 1'b0;
  logic          rst;
  logic [EW-1:0] fifo_rd_data_i = '0;
  logic          fifo_empty_i;
  logic          fifo_rd_en_o;
  logic          bus_req_o;
  logic [AW-1:0] bus_adr_o;
  logic [DW-1:0] bus_dat_o;
  logic [SW-1:0] bus_sel_o;
  logic          bus_ack_i;
  logic          bus_err_i;
  logic          err_o;
  logic          drained_o;

  logic [EW-1:0] mem [16];
  logic [3:0]    wr_ptr = '0;
  logic [3:0]    rd_ptr = '0;
  logic          hide = 1'b0;
  int            pop_cnt = 0;

  int checks = 0;
  int passes = 0;

  logic [31:0]   req_bits;
  logic [31:0]   err_bits;
  logic [AW-1:0] adr_log [8];
  logic [DW-1:0] dat_log [8];
  logic [SW-1:0] sel_log [8];
  int            nret;
  int            start_c;

  sb_drain dut (
    .clk(clk), .rst(rst),
    .fifo_rd_data_i(fifo_rd_data_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
    .bus_req_o(bus_req_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_sel_o(bus_sel_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .err_o(err_o), .drained_o(drained_o)
  );

  always #5 clk = ~clk;

  // hide lets a scenario make the FIFO look empty while entries remain.
  assign fifo_empty_i = (wr_ptr == rd_ptr) || hide;

  always @(posedge clk) begin
    if (fifo_rd_en_o) begin
      fifo_rd_data_i <= mem[rd_ptr];
      rd_ptr         <= rd_ptr + 4'd1;
      pop_cnt        <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    mem[wr_ptr] = {a, d, s};
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Acts as the bus slave for 16 cycles: acks (or errs write err_at) 'delay' cycles into each request.
  task automatic serve(input int n, input int delay, input int err_at);
    int  wait_cnt;
    bit  started;
    wait_cnt = 0;
    started  = 1'b0;
    nret     = 0;
    start_c  = -1;
    req_bits = '0;
    err_bits = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      if (bus_req_o && !started) begin
        started = 1'b1;
        start_c = c;
      end
      if (started) begin
        req_bits[c-start_c] = bus_req_o;
        err_bits[c-start_c] = err_o;
      end
      if (bus_req_o && nret < n) begin
        if (wait_cnt == delay) begin
          if (nret == err_at) bus_err_i = 1'b1;
          else bus_ack_i = 1'b1;
          adr_log[nret] = bus_adr_o;
          dat_log[nret] = bus_dat_o;
          sel_log[nret] = bus_sel_o;
          $display("write %0d adr=%h dat=%h sel=%h %s", nret, bus_adr_o, bus_dat_o, bus_sel_o,
                   bus_err_i ? "err" : "ack");
          nret++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_ack_i = 1'b0;
    bus_err_i = 1'b0;
    push(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (fifo_rd_en_o !== 1'b0) $display("FAIL reset_rd_en[%0d]: got %b want 0", i, fifo_rd_en_o); else passes++;
    end
    rst = 1'b0;
    #1;
    checks++; if (bus_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", bus_req_o); else passes++;
    checks++; if (drained_o !== 1'b0) $display("FAIL reset_drained: got %b want 0", drained_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else passes++;
    checks++; if (bus_adr_o !== 32'h0) $display("FAIL reset_adr: got %h want 0", bus_adr_o); else passes++;
    checks++; if (fifo_rd_en_o !== 1'b1) $display("FAIL release_pop: got %b want 1", fifo_rd_en_o); else passes++;
  endtask

  // Continues from the pop cycle left by test_reset.
  task automatic test_single();
    serve(1, 3, -1);
    checks++; if (start_c !== 1) $display("FAIL single_latency: got %0d want 1", start_c); else passes++;
    checks++; if (req_bits[4:0] !== 5'b01111) $display("FAIL single_req_pattern: got %b want 01111", req_bits[4:0]); else passes++;
    checks++; if (adr_log[0] !== 32'h0000_1000) $display("FAIL single_adr: got %h want 00001000", adr_log[0]); else passes++;
    checks++; if (dat_log[0] !== 32'hDEAD_BEEF) $display("FAIL single_dat: got %h want deadbeef", dat_log[0]); else passes++;
    checks++; if (sel_log[0] !== 4'hF) $display("FAIL single_sel: got %h want f", sel_log[0]); else passes++;
    checks++; if (drained_o !== 1'b1) $display("FAIL single_drained: got %b want 1", drained_o); else passes++;
  endtask

  task automatic test_back_to_back();
    int pops;
    pops = pop_cnt;
    push(32'h2000, 32'h1111_1111, 4'h1);
    push(32'h2004, 32'h2222_2222, 4'h3);
    push(32'h2008, 32'h3333_3333, 4'hC);
    serve(3, 0, -1);
`ifdef SB_DRAIN_PREFETCH_EN
    checks++; if (req_bits[4:0] !== 5'b00111) $display("FAIL b2b_req_pattern: got %b want 00111", req_bits[4:0]); else passes++;
`else
    checks++; if (req_bits[4:0] !== 5'b10101) $display("FAIL b2b_req_pattern: got %b want 10101", req_bits[4:0]); else passes++;
`endif
    checks++; if (pop_cnt - pops !== 3) $display("FAIL b2b_pops: got %0d want 3", pop_cnt - pops); else passes++;
    checks++; if (adr_log[0] !== 32'h2000) $display("FAIL b2b_adr0: got %h want 2000", adr_log[0]); else passes++;
    checks++; if (adr_log[1] !== 32'h2004) $display("FAIL b2b_adr1: got %h want 2004", adr_log[1]); else passes++;
    checks++; if (adr_log[2] !== 32'h2008) $display("FAIL b2b_adr2: got %h want 2008", adr_log[2]); else passes++;
    checks++; if (sel_log[2] !== 4'hC) $display("FAIL b2b_sel2: got %h want c", sel_log[2]); else passes++;
    checks++; if (err_bits !== 32'h0) $display("FAIL b2b_no_err: got %h want 0", err_bits); else passes++;
    checks++; if (drained_o !== 1'b1) $display("FAIL b2b_drained: got %b want 1", drained_o); else passes++;
  endtask

  task automatic test_error();
    int pops;
    pops = pop_cnt;
    push(32'h3000, 32'hA0A0_A0A0, 4'hF);
    push(32'h3004, 32'hB0B0_B0B0, 4'hF);
    push(32'h3008, 32'hC0C0_C0C0, 4'hF);
    serve(3, 0, 1);
    checks++; if ($countones(err_bits) !== 1) $display("FAIL err_pulse_len: got %0d want 1", $countones(err_bits)); else passes++;
`ifdef SB_DRAIN_PREFETCH_EN
    checks++; if (err_bits[2] !== 1'b1) $display("FAIL err_pulse_pos: got %b want 1 at idx2", err_bits[2]); else passes++;
`else
    checks++; if (err_bits[3] !== 1'b1) $display("FAIL err_pulse_pos: got %b want 1 at idx3", err_bits[3]); else passes++;
`endif
    checks++; if (nret !== 3) $display("FAIL err_writes: got %0d want 3", nret); else passes++;
    checks++; if (adr_log[2] !== 32'h3008) $display("FAIL err_third_adr: got %h want 3008", adr_log[2]); else passes++;
    checks++; if (pop_cnt - pops !== 3) $display("FAIL err_no_retry: got %0d pops want 3", pop_cnt - pops); else passes++;
    checks++; if (err_o !== 1'b0) $display("FAIL err_idle: got %b want 0", err_o); else passes++;
  endtask

  task automatic test_empty_boundary();
    bit got;
    push(32'h5000, 32'h5555_0000, 4'hF);
    push(32'h5004, 32'h5555_0004, 4'hF);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus_req_o) got = 1'b1;
    end
    checks++; if (got !== 1'b1) $display("FAIL bnd_req_timeout: got %b want 1", got); else passes++;
    hide = 1'b1;
    bus_ack_i = 1'b1;
    #1;
    checks++; if (fifo_rd_en_o !== 1'b0) $display("FAIL bnd_no_pop: got %b want 0", fifo_rd_en_o); else passes++;
`ifdef SB_DRAIN_PREFETCH_EN
    @(negedge clk);
    checks++; if (bus_adr_o !== 32'h5004) $display("FAIL bnd_prefetched_adr: got %h want 5004", bus_adr_o); else passes++;
`endif
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    checks++; if (bus_req_o !== 1'b0) $display("FAIL bnd_req_low: got %b want 0", bus_req_o); else passes++;
    checks++; if (drained_o !== 1'b1) $display("FAIL bnd_drained: got %b want 1", drained_o); else passes++;
    checks++; if (fifo_rd_en_o !== 1'b0) $display("FAIL bnd_no_pop2: got %b want 0", fifo_rd_en_o); else passes++;
    hide = 1'b0;
`ifndef SB_DRAIN_PREFETCH_EN
    serve(1, 0, -1);
    checks++; if (adr_log[0] !== 32'h5004) $display("FAIL bnd_next_adr: got %h want 5004", adr_log[0]); else passes++;
`endif
  endtask

  task automatic test_reset_mid_write();
    bit got;
    int pops;
    push(32'h4000, 32'h4444_0000, 4'hF);
    push(32'h4004, 32'h4444_0004, 4'hF);
    push(32'h4008, 32'h4444_0008, 4'hF);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus_req_o) got = 1'b1;
    end
    checks++; if (got !== 1'b1) $display("FAIL mid_req_timeout: got %b want 1", got); else passes++;
    rst = 1'b1;
    #1;
    pops = pop_cnt;
    checks++; if (fifo_rd_en_o !== 1'b0) $display("FAIL mid_rd_en_in_rst: got %b want 0", fifo_rd_en_o); else passes++;
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0) $display("FAIL mid_req_drop: got %b want 0", bus_req_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("FAIL mid_err: got %b want 0", err_o); else passes++;
    @(negedge clk);
    checks++; if (pop_cnt !== pops) $display("FAIL mid_pop_in_rst: got %0d want %0d", pop_cnt, pops); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (fifo_rd_en_o !== 1'b1) $display("FAIL mid_release_pop: got %b want 1", fifo_rd_en_o); else passes++;
`ifdef SB_DRAIN_PREFETCH_EN
    serve(1, 1, -1);
    checks++; if (adr_log[0] !== 32'h4008) $display("FAIL mid_resume_adr: got %h want 4008", adr_log[0]); else passes++;
    checks++; if (nret !== 1) $display("FAIL mid_resume_cnt: got %0d want 1", nret); else passes++;
`else
    serve(2, 1, -1);
    checks++; if (adr_log[0] !== 32'h4004) $display("FAIL mid_resume_adr: got %h want 4004", adr_log[0]); else passes++;
    checks++; if (nret !== 2) $display("FAIL mid_resume_cnt: got %0d want 2", nret); else passes++;
`endif
    checks++; if (drained_o !== 1'b1) $display("FAIL mid_drained: got %b want 1", drained_o); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_error();
    test_empty_boundary();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
